// File: rtl/fadd_near_round_if.sv
// Handshake and payload bundle between the FP-add near path, the rounding
// stage and its writeback consumer.
interface fadd_near_round_if #(
  parameter int EXPWIDTH = 8,
  parameter int OUTPC    = 24,
  parameter int TAG_W    = 8
);
  logic                         in_valid;
  logic                         in_ready;
  logic                         in_sign;
  logic [EXPWIDTH-1:0]          in_exp;
  logic [OUTPC+2:0]             in_sig;
  logic                         in_sig_is_zero;
  logic [2:0]                   in_rm;
  logic [TAG_W-1:0]             in_tag;
  logic                         out_valid;
  logic                         out_ready;
  logic [EXPWIDTH+OUTPC-1:0]    out_result;
  logic [4:0]                   out_fflags;
  logic [TAG_W-1:0]             out_tag;

  modport master (
    output in_valid, in_sign, in_exp, in_sig, in_sig_is_zero, in_rm, in_tag,
    output out_ready,
    input  in_ready, out_valid, out_result, out_fflags, out_tag
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_sig, in_sig_is_zero, in_rm, in_tag,
    input  out_ready,
    output in_ready, out_valid, out_result, out_fflags, out_tag
  );
endinterface

// File: rtl/fadd_near_round.sv
// Two-stage IEEE-754 rounding and packing stage for the FP-add near path:
// S1 decides the rounding increment, S2 applies it and packs result/flags.
module fadd_near_round #(
  parameter int EXPWIDTH = 8,
  parameter int OUTPC    = 24,
  parameter int TAG_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  fadd_near_round_if.slave bus
);
  localparam logic [2:0] RM_RTZ = 3'd1;
  localparam logic [2:0] RM_RDN = 3'd2;
  localparam logic [2:0] RM_RUP = 3'd3;
  localparam logic [2:0] RM_RMM = 3'd4;
  localparam logic [EXPWIDTH-1:0] EXP_ONES = {EXPWIDTH{1'b1}};
  localparam logic [EXPWIDTH-1:0] EXP_ONE  = {{(EXPWIDTH-1){1'b0}}, 1'b1};

  logic s1_valid_reg;
  logic s2_valid_reg;
  logic s1_adv;
  logic in_fire;

  assign s1_adv       = !s2_valid_reg || bus.out_ready;
  assign bus.in_ready = !s1_valid_reg || s1_adv;
  assign in_fire      = bus.in_valid && bus.in_ready;

  // S1 rounding decision
  logic lsb, guard, sticky;
  logic inexact_next, inc_next, tiny_next;

  always_comb begin
    lsb          = bus.in_sig[3];
    guard        = bus.in_sig[2];
    sticky       = |bus.in_sig[1:0];
    inexact_next = guard | sticky;
    case (bus.in_rm)
      RM_RTZ:  inc_next = 1'b0;
      RM_RDN:  inc_next = inexact_next & bus.in_sign;
      RM_RUP:  inc_next = inexact_next & !bus.in_sign;
      RM_RMM:  inc_next = guard;
      default: inc_next = guard & (sticky | lsb);
    endcase
    tiny_next = (bus.in_exp == '0) && inexact_next;
  end

  logic                s1_sign_reg;
  logic [EXPWIDTH-1:0] s1_exp_reg;
  logic [OUTPC-1:0]    s1_sig_reg;
  logic                s1_inc_reg, s1_inexact_reg, s1_tiny_reg, s1_zero_reg;
  logic [2:0]          s1_rm_reg;
  logic [TAG_W-1:0]    s1_tag_reg;

  always_ff @(posedge clk) begin
    if (rst)          s1_valid_reg <= 1'b0;
    else if (in_fire) s1_valid_reg <= 1'b1;
    else if (s1_adv)  s1_valid_reg <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (in_fire) begin
      s1_sign_reg    <= bus.in_sign;
      s1_exp_reg     <= bus.in_exp;
      s1_sig_reg     <= bus.in_sig[OUTPC+2:3];
      s1_inc_reg     <= inc_next;
      s1_inexact_reg <= inexact_next;
      s1_tiny_reg    <= tiny_next;
      s1_zero_reg    <= bus.in_sig_is_zero;
      s1_rm_reg      <= bus.in_rm;
      s1_tag_reg     <= bus.in_tag;
    end
  end

  // S2 increment, carry renormalisation, overflow and packing
  logic [OUTPC:0]               sum;
  logic [OUTPC-1:0]             sig_rnd;
  logic [EXPWIDTH-1:0]          exp_rnd;
  logic                         ovf, ovf_to_inf;
  logic [EXPWIDTH+OUTPC-1:0]    result_next;
  logic [4:0]                   fflags_next;

  always_comb begin
    sum     = {1'b0, s1_sig_reg} + {{OUTPC{1'b0}}, s1_inc_reg};
    sig_rnd = sum[OUTPC-1:0];
    exp_rnd = s1_exp_reg;
    if (sum[OUTPC]) begin
      sig_rnd = sum[OUTPC:1];
      exp_rnd = s1_exp_reg + EXP_ONE;
    end else if (s1_exp_reg == '0 && sum[OUTPC-1]) begin
      exp_rnd = EXP_ONE;
    end
    ovf = (exp_rnd == EXP_ONES);
    case (s1_rm_reg)
      RM_RTZ:  ovf_to_inf = 1'b0;
      RM_RDN:  ovf_to_inf = s1_sign_reg;
      RM_RUP:  ovf_to_inf = !s1_sign_reg;
      default: ovf_to_inf = 1'b1;
    endcase

    result_next = {s1_sign_reg, exp_rnd, sig_rnd[OUTPC-2:0]};
    fflags_next = {2'b00, ovf, s1_tiny_reg, s1_inexact_reg | ovf};
    if (s1_zero_reg) begin
      result_next = {s1_rm_reg == RM_RDN, {EXPWIDTH{1'b0}}, {(OUTPC-1){1'b0}}};
      fflags_next = 5'b00000;
    end else if (ovf) begin
      // Directions that round away from the overflow saturate at max-finite
      if (ovf_to_inf)
        result_next = {s1_sign_reg, EXP_ONES, {(OUTPC-1){1'b0}}};
      else
        result_next = {s1_sign_reg, EXP_ONES - EXP_ONE, {(OUTPC-1){1'b1}}};
    end
  end

  logic [EXPWIDTH+OUTPC-1:0] s2_result_reg;
  logic [4:0]                s2_fflags_reg;
  logic [TAG_W-1:0]          s2_tag_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_reg  <= 1'b0;
      s2_result_reg <= '0;
      s2_fflags_reg <= '0;
      s2_tag_reg    <= '0;
    end else if (s1_adv) begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        s2_result_reg <= result_next;
        s2_fflags_reg <= fflags_next;
        s2_tag_reg    <= s1_tag_reg;
      end
    end
  end

  assign bus.out_valid  = s2_valid_reg;
  assign bus.out_result = s2_result_reg;
  assign bus.out_fflags = s2_fflags_reg;
  assign bus.out_tag    = s2_tag_reg;
endmodule
